file_unit: RTL and testbench



---
 rtl/file_pkg.sv | 18 +
 rtl/file_delay.sv | 30 +++
 rtl/file_unit.sv | 82 ++++++++
 tb/tb_file_unit.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/file_pkg.sv
// Shared constants and helpers for the file_unit MAC slice.
package file_pkg;

  localparam int FILE_WIDTH     = 8;
  localparam int FILE_PAR       = 3;
  localparam int FILE_MUL_WIDTH = 16;
  localparam int FILE_X_WIDTH   = 5;

  // Clamp a wide accumulator value to the largest value representable in
  // `width` bits. The caller keeps only the low `width` bits of the result.
  function automatic logic [63:0] sat_narrow(input logic [63:0] value,
                                             input int unsigned width);
    logic [63:0] max_v;
    max_v = (64'd1 << width) - 64'd1;
    return (value > max_v) ? max_v : value;
  endfunction

endpackage

// File: rtl/file_delay.sv
// WIDTH x DEPTH shift register with synchronous clear; feeds the parity tap.
module file_delay #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // First stage captures the input on every edge.
  always_ff @(posedge clk) begin
    if (rst) stage_q[0] <= '0;
    else     stage_q[0] <= din;
  end

  // Remaining stages shift one step per edge; reset flushes the whole line.
  for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
    always_ff @(posedge clk) begin
      if (rst) stage_q[gi] <= '0;
      else     stage_q[gi] <= stage_q[gi-1];
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/file_unit.sv
// file_unit: multiply-accumulate with narrow readout, sticky wrap flag and a
// delayed parity tap. Define FILE_SAT_EN to saturate data_out instead of
// truncating it.
module file_unit
  import file_pkg::*;
#(
  parameter int WIDTH     = FILE_WIDTH,
  parameter int par       = FILE_PAR,
  parameter int MUL_WIDTH = FILE_MUL_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        data_in,
  input  logic                    a,
  input  logic                    b,
  input  logic [FILE_X_WIDTH-1:0] x,
  output logic [WIDTH-1:0]        data_out,
  output logic                    out,
  output logic                    d
);

  localparam int PW = WIDTH + FILE_X_WIDTH;

  logic [PW-1:0]        prod;
  logic [MUL_WIDTH-1:0] p_ext;
  logic [MUL_WIDTH:0]   sum_d;
  logic [MUL_WIDTH-1:0] acc_q, acc_d;
  logic                 out_q, out_d;
  logic [WIDTH-1:0]     tap;

  assign prod  = {{FILE_X_WIDTH{1'b0}}, data_in} * {{WIDTH{1'b0}}, x};
  assign p_ext = MUL_WIDTH'(prod);
  assign sum_d = {1'b0, acc_q} + {1'b0, p_ext};

  // Next-state for accumulator and wrap flag; restart and clear both drop the flag.
  always_comb begin
    acc_d = acc_q;
    out_d = out_q;
    if (b && a) begin
      acc_d = p_ext;
      out_d = 1'b0;
    end else if (b) begin
      acc_d = '0;
      out_d = 1'b0;
    end else if (a) begin
      acc_d = sum_d[MUL_WIDTH-1:0];
      if (sum_d[MUL_WIDTH]) out_d = 1'b1;
    end
  end

  // Accumulator and sticky flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      out_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      out_q <= out_d;
    end
  end

`ifdef FILE_SAT_EN
  assign data_out = WIDTH'(sat_narrow(64'(acc_q), WIDTH));
`else
  assign data_out = acc_q[WIDTH-1:0];
`endif

  assign out = out_q;

  file_delay #(
    .WIDTH (WIDTH),
    .DEPTH (par)
  ) u_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (data_in),
    .dout (tap)
  );

  assign d = ^tap;

endmodule

// File: tb/tb_file_unit.sv
// Directed self-checking bench for file_unit (default parameters).
module tb_file_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       a, b;
  logic [4:0] x;
  logic [7:0] data_out;
  logic       out;
  logic       d;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  file_unit file (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .a        (a),
    .b        (b),
    .x        (x),
    .data_out (data_out),
    .out      (out),
    .d        (d)
  );

  // Advance one rising edge, then sample 1 time unit later.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic aa, input logic bb,
                       input logic [7:0] di, input logic [4:0] xx);
    rst = r; a = aa; b = bb; data_in = di; x = xx;
  endtask

  logic [7:0] exp_e8, exp_e9;

  initial begin
`ifdef FILE_SAT_EN
    exp_e8 = 8'd255;
    exp_e9 = 8'd255;
`else
    exp_e8 = 8'd8;
    exp_e9 = 8'd233;
`endif
    // Reset with random inputs for two edges
    drive(1'b1, 1'($urandom), 1'($urandom), 8'($urandom), 5'($urandom));
    step(1);
    drive(1'b1, 1'($urandom), 1'($urandom), 8'($urandom), 5'($urandom));
    step(1);
    check("rst_data_out", 32'(data_out), 0);
    check("rst_out", 32'(out), 0);
    check("rst_d", 32'(d), 0);

    // Single MAC then hold
    drive(1'b0, 1'b1, 1'b0, 8'd10, 5'd3); step(1);
    check("mac_30", 32'(data_out), 30);
    check("mac_out", 32'(out), 0);
    drive(1'b0, 1'b0, 1'b0, 8'd99, 5'd7); step(1);
    check("hold_30", 32'(data_out), 30);

    // Zero multiplier / zero multiplicand leave acc alone
    drive(1'b0, 1'b1, 1'b0, 8'd200, 5'd0); step(1);
    check("x0_hold", 32'(data_out), 30);
    drive(1'b0, 1'b1, 1'b0, 8'd0, 5'd31); step(1);
    check("din0_hold", 32'(data_out), 30);
    check("zero_out", 32'(out), 0);

    // Clear
    drive(1'b0, 1'b0, 1'b1, 8'd50, 5'd5); step(1);
    check("clr0", 32'(data_out), 0);

    // Saturation and wrap: 255*31 = 7905 per edge
    drive(1'b0, 1'b1, 1'b0, 8'd255, 5'd31); step(8);
    check("e8_data_out", 32'(data_out), 32'(exp_e8));
    check("e8_out", 32'(out), 0);
    step(1);
    check("e9_data_out", 32'(data_out), 32'(exp_e9));
    check("e9_out", 32'(out), 1);
    drive(1'b0, 1'b0, 1'b0, 8'd255, 5'd31); step(1);
    check("sticky_out", 32'(out), 1);
    check("hold_e9", 32'(data_out), 32'(exp_e9));

    // Restart while flag set drops flag and loads product
    drive(1'b0, 1'b1, 1'b1, 8'd4, 5'd2); step(1);
    check("restart_8", 32'(data_out), 8);
    check("restart_out", 32'(out), 0);

    // Clear then restart
    drive(1'b0, 1'b0, 1'b1, 8'd0, 5'd0); step(1);
    check("clr_data_out", 32'(data_out), 0);
    check("clr_out", 32'(out), 0);
    drive(1'b0, 1'b1, 1'b1, 8'd4, 5'd2); step(1);
    check("restart2_8", 32'(data_out), 8);

    // Parity tap: flush with zeros, then one odd-parity sample
    drive(1'b0, 1'b0, 1'b0, 8'h00, 5'd0); step(3);
    check("par_flushed", 32'(d), 0);
    drive(1'b0, 1'b0, 1'b0, 8'h07, 5'd0); step(1);
    check("par_k", 32'(d), 0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 5'd0); step(1);
    check("par_k1", 32'(d), 0);
    step(1);
    check("par_k2", 32'(d), 1);
    step(1);
    check("par_k3", 32'(d), 0);
    drive(1'b0, 1'b0, 1'b0, 8'h03, 5'd0); step(1);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 5'd0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("par_even", 32'(d), 0);
    end
    check("par_acc_hold", 32'(data_out), 8);

    // Reset mid-run: acc 8 -> 15 -> 22 -> 29, pipeline full of 8'h07
    drive(1'b0, 1'b1, 1'b0, 8'h07, 5'd1); step(3);
    check("mid_acc_29", 32'(data_out), 29);
    check("mid_d_loaded", 32'(d), 1);
    drive(1'b1, 1'b1, 1'b0, 8'h07, 5'd1); step(1);
    check("mid_rst_data_out", 32'(data_out), 0);
    check("mid_rst_out", 32'(out), 0);
    check("mid_rst_d", 32'(d), 0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 5'd0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("post_rst_d", 32'(d), 0);
    end
    check("post_rst_data_out", 32'(data_out), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
